// File: rtl/seq5_checker.sv
// seq5_checker: self-synchronising receive checker for the 5-bit shift-register sequence generator
module seq5_checker #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [4:0]       in_word,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [4:0]       exp_word
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_CNT - 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t        state;
    logic [GW-1:0] good;
    logic [BW-1:0] bad;
    logic          match, err;

    function automatic logic [4:0] nxt(input logic [4:0] w);
        return {w[3] ^ w[4], w[2] | w[4], w[1], w[0], w[4]};
    endfunction

    assign match = in_word == exp_word;
    assign err   = in_valid && state == LOCKED && !match;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            good      <= '0;
            bad       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            exp_word  <= '0;
        end else begin
            err_pulse <= err;
            if (clr_cnt)
                err_cnt <= err ? ERR_W'(1) : '0;
            else if (err && !(&err_cnt))
                err_cnt <= err_cnt + ERR_W'(1);
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        exp_word <= nxt(in_word);
                        good     <= '0;
                        state    <= VERIFY;
                    end
                    VERIFY: begin
                        exp_word <= nxt(in_word);
                        good     <= match ? good + GW'(1) : '0;
                        if (match && good == GOOD_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            bad    <= '0;
                        end
                    end
                    LOCKED: begin
                        // flywheel: once locked, never reseed from received data
                        exp_word <= nxt(exp_word);
                        bad      <= match ? '0 : bad + BW'(1);
                        if (!match && bad == BAD_LAST) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seq5_checker.sv
// tb_seq5_checker: scoreboard bench for two checker configurations driven by the same stream
module tb_seq5_checker;
    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clr_cnt = 1'b0;
    logic [4:0] in_word = '0;
    logic       l0, p0, l1, p1;
    logic [7:0] c0;
    logic [1:0] c1;
    logic [4:0] e0, e1;

    always #5 clk = ~clk;

    seq5_checker d0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .clr_cnt(clr_cnt),
                     .locked(l0), .err_pulse(p0), .err_cnt(c0), .exp_word(e0));
    seq5_checker #(.LOCK_CNT(3), .LOSS_CNT(8), .ERR_W(2)) d1 (
                     .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word), .clr_cnt(clr_cnt),
                     .locked(l1), .err_pulse(p1), .err_cnt(c1), .exp_word(e1));

    typedef struct packed {logic lk; logic pl; logic [7:0] cnt; logic [4:0] ex;} resp_t;
    resp_t q0[$], q1[$];
    int n_chk = 0, n_fail = 0;

    // reference model: 0 = hunting, 1 = verifying, 2 = locked
    int         mode[2], good[2], bad[2], cnt[2];
    logic [4:0] ex[2];
    logic       lk[2], pl[2];
    int         loss_p[2] = '{2, 8};
    int         cmax[2]   = '{255, 3};

    function automatic logic [4:0] nxt(input logic [4:0] w);
        return {w[3] ^ w[4], w[2] | w[4], w[1], w[0], w[4]};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [4:0] w, input logic c);
        resp_t x;
        logic  e;
        @(negedge clk);
        rst = r; in_valid = v; in_word = w; clr_cnt = c;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mode[k] = 0; good[k] = 0; bad[k] = 0; cnt[k] = 0; ex[k] = '0; lk[k] = 0; pl[k] = 0;
            end else begin
                e = 0;
                if (v) begin
                    if (mode[k] == 0) begin
                        ex[k] = nxt(w); good[k] = 0; mode[k] = 1;
                    end else if (mode[k] == 1) begin
                        good[k] = (w == ex[k]) ? good[k] + 1 : 0;
                        ex[k] = nxt(w);
                        if (good[k] == 3) begin mode[k] = 2; lk[k] = 1; bad[k] = 0; end
                    end else begin
                        if (w == ex[k]) bad[k] = 0;
                        else begin
                            e = 1; bad[k]++;
                            if (bad[k] == loss_p[k]) begin mode[k] = 0; lk[k] = 0; end
                        end
                        ex[k] = nxt(ex[k]);
                    end
                end
                pl[k] = e;
                if (c) cnt[k] = e ? 1 : 0;
                else if (e && cnt[k] < cmax[k]) cnt[k]++;
            end
            x = '{lk[k], pl[k], 8'(cnt[k]), ex[k]};
            if (k == 0) q0.push_back(x); else q1.push_back(x);
        end
    endtask

    initial forever begin
        resp_t r;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            r = q0.pop_front();
            chk("d0.locked", l0, r.lk);
            chk("d0.err_pulse", p0, r.pl);
            chk("d0.err_cnt", c0, r.cnt);
            chk("d0.exp_word", e0, r.ex);
        end
        if (q1.size() > 0) begin
            r = q1.pop_front();
            chk("d1.locked", l1, r.lk);
            chk("d1.err_pulse", p1, r.pl);
            chk("d1.err_cnt", c1, r.cnt);
            chk("d1.exp_word", e1, r.ex);
        end
    end

    initial begin
        logic [4:0] g;
        logic       v;
        repeat (2) step(1, 1, 5'($urandom), 0);
        // acquire, single error, loss and relock
        step(0, 1, 5'b11111, 0);
        step(0, 1, 5'b01111, 0);
        step(0, 1, 5'b11110, 0);
        step(0, 1, 5'b01101, 0);
        step(0, 1, 5'b11010, 0);
        step(0, 1, 5'b00000, 0);
        step(0, 1, 5'b11010, 0);
        step(0, 1, 5'b00000, 0);
        step(0, 1, 5'b00000, 0);
        step(0, 1, 5'b01101, 0);
        step(0, 1, 5'b11010, 0);
        step(0, 1, 5'b01101, 0);
        step(0, 1, 5'b11010, 0);
        // valid gaps then the correct word
        repeat (3) step(0, 0, 5'($urandom), 0);
        step(0, 1, 5'b01101, 0);
        // saturation on the narrow counter, clear with error, reset while locked
        repeat (5) step(0, 1, 5'b00000, 0);
        step(0, 1, 5'b00000, 1);
        step(0, 0, 5'b00000, 1);
        step(1, 1, 5'b11010, 0);
        step(0, 0, 5'b00000, 0);
        // randomized stream: mostly true generator output with corruption, gaps, clears, resets
        g = 5'b11111;
        for (int i = 0; i < 3000; i++) begin
            v = $urandom_range(0, 9) != 0;
            step($urandom_range(0, 299) == 0, v,
                 ($urandom_range(0, 19) == 0) ? 5'($urandom) : g,
                 $urandom_range(0, 49) == 0);
            if (v) g = nxt(g);
            if ($urandom_range(0, 999) == 0) g = 5'($urandom);
        end
        repeat (2) step(0, 0, 5'b00000, 0);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq5_checker.md
Name: seq5_checker

Overview:
- Receive-side checker for the 5-bit shift-register sequence generator used in this codebase.
- Accepts one 5-bit generator state word per valid cycle, self-synchronises to the stream, then predicts each next word and flags mismatches.
- Sits at the far end of a link or bus carrying generator output; reports lock status and a saturating error count for link bring-up and BIST.

Parameters:
LOCK_CNT, 3, consecutive correct predictions needed to declare lock (>=1)
LOSS_CNT, 2, consecutive mispredictions in lock that drop lock (>=1)
ERR_W, 8, width of error counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  in_word is a valid sample this cycle
in_word  in  5  received generator state, bit i = stage i
clr_cnt  in  1  synchronous clear of err_cnt
locked  out  1  checker is in LOCKED state
err_pulse  out  1  one-cycle flag: a valid sample mismatched while locked
err_cnt  out  ERR_W  saturating count of mismatches while locked
exp_word  out  5  word predicted for the next valid sample

Behaviour:
- Reset and clock: only clk and rst are used. Reset is synchronous and active-high; it is sampled on the rising clk edge.
- Prediction function nxt(w), where w is the current 5-bit word:
  - nxt[0] = w[4]
  - nxt[1] = w[0]
  - nxt[2] = w[1]
  - nxt[3] = w[2] | w[4]
  - nxt[4] = w[3] ^ w[4]
- Reset: locked=0, err_pulse=0, err_cnt=0, exp_word=5'b00000. Internal state goes to HUNT; good and bad counters = 0. Reset mid-operation overrides all other inputs.
- All outputs are registered. A response to a sample appears in the cycle after the edge that captures it.
- in_valid=0: no state, counter or exp_word change; err_pulse=0.
- States:
  - HUNT: on valid, exp_word<=nxt(in_word), good=0, go to VERIFY.
  - VERIFY, valid with in_word==exp_word: exp_word<=nxt(in_word), good++. If good reaches LOCK_CNT: go to LOCKED, locked<=1, bad=0.
  - VERIFY, valid with mismatch: reseed exp_word<=nxt(in_word), good=0, stay in VERIFY. No error is counted.
  - LOCKED, valid with match: exp_word<=nxt(exp_word), bad=0.
  - LOCKED, valid with mismatch: err_pulse<=1, err_cnt saturating +1, bad++, exp_word<=nxt(exp_word) (flywheel: never reseed from bad data). If bad reaches LOSS_CNT: go to HUNT, locked<=0.
- err_pulse is high for exactly one cycle per mismatching locked sample. It is 0 otherwise.
- err_cnt:
  - Holds at 2^ERR_W-1 once reached.
  - clr_cnt alone sets it to 0.
  - clr_cnt in the same cycle as a counted error sets it to 1.
  - It is not cleared by losing lock.
- Lock loss and relock: the sample that triggers loss is still counted as an error. Relock needs 1 seed sample plus LOCK_CNT matches.
- Reference sequence from generator preset 11111 (written q4..q0): 11111, 01111, 11110, 01101, 11010, then it alternates 01101/11010.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and random in_word -> locked=0, err_pulse=0, err_cnt=0, exp_word=00000 throughout.
- Acquire (defaults): valid words 11111, 01111, 11110, 01101 on consecutive cycles -> exp_word=01111 after the 1st edge; locked=1 the cycle after the 4th sample; err_cnt=0.
- Single error in lock: continue with 11010, then 00000 in place of 01101, then 11010 -> err_pulse high one cycle after 00000; err_cnt=1; locked stays 1; the final 11010 matches the flywheel prediction.
- Loss and relock: in lock, send 00000 twice -> err_pulse on both, err_cnt +2, locked=0 after the 2nd. Then 01101, 11010, 01101, 11010 -> locked=1 again.
- Valid gaps: in lock, drop in_valid for 3 cycles -> exp_word, locked and err_cnt unchanged, err_pulse=0. Resume with the correct word -> no error.
- Saturation, clear, mid-run reset (ERR_W=2): 5 locked errors with LOSS_CNT=8 -> err_cnt stops at 3. clr_cnt together with an error -> err_cnt=1. rst=1 while locked -> all outputs back to reset values next cycle.
